// File: rtl/div_tick_monitor.sv
// Monitors the div4/div16 outputs of the clock divider: one-cycle ticks on each
// rising edge, rise-to-rise period measurement, and a per-channel lock FSM.

module div_tick_chan #(
    parameter int CNT_W    = 8,
    parameter int EXP      = 4,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    output logic             tick,
    output logic [CNT_W-1:0] period,
    output logic             lock,
    output logic             err_set
);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_LOCKED  = 2'd3;

    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_STALL = CNT_MAX - 1'b1;
    localparam logic [CNT_W-1:0]   EXP_C     = CNT_W'(EXP);
    localparam logic [MATCH_W-1:0] LOCK_C    = MATCH_W'(LOCK_CNT);

    logic               in_d_q,   in_d_d;
    logic               tick_q,   tick_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [MATCH_W-1:0] match_q,  match_d;
    logic [1:0]         state_q,  state_d;
    logic               lock_q,   lock_d;
    logic               rise;

    // NOTE: every signal gets a default at the top of the block so no path
    // through the case/if tree leaves one unassigned and infers a latch.
    always_comb begin
        rise     = div_in & ~in_d_q;
        in_d_d   = div_in;
        tick_d   = rise & en;
        cnt_d    = rise ? CNT_W'(1) : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
        state_d  = state_q;
        match_d  = match_q;
        period_d = period_q;
        err_set  = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            match_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                    match_d = '0;
                end
                ST_WAIT: begin
                    if (rise) state_d = ST_MEASURE;
                end
                default: begin
                    if (rise) begin
                        period_d = cnt_q;
                        if (cnt_q == EXP_C) begin
                            match_d = (match_q == LOCK_C) ? match_q : match_q + 1'b1;
                            if (state_q == ST_MEASURE && match_d == LOCK_C)
                                state_d = ST_LOCKED;
                        end else begin
                            match_d = '0;
                            if (state_q == ST_LOCKED) begin
                                state_d = ST_MEASURE;
                                err_set = 1'b1;
                            end
                        end
                    end else if (cnt_q == CNT_STALL) begin
                        // Counter saturates this edge: the input has stalled.
                        state_d = ST_WAIT;
                        match_d = '0;
                        err_set = 1'b1;
                    end
                end
            endcase
        end

        lock_d = (state_d == ST_LOCKED);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample their _d values from the same edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_d_q   <= 1'b0;
            tick_q   <= 1'b0;
            cnt_q    <= '0;
            period_q <= '0;
            match_q  <= '0;
            state_q  <= ST_IDLE;
            lock_q   <= 1'b0;
        end else begin
            in_d_q   <= in_d_d;
            tick_q   <= tick_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            match_q  <= match_d;
            state_q  <= state_d;
            lock_q   <= lock_d;
        end
    end

    assign tick   = tick_q;
    assign period = period_q;
    assign lock   = lock_q;
endmodule

module div_tick_monitor #(
    parameter int CNT_W    = 8,
    parameter int EXP_P4   = 4,
    parameter int EXP_P16  = 16,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_err,
    input  logic             div4_in,
    input  logic             div16_in,
    output logic             tick4,
    output logic             tick16,
    output logic [CNT_W-1:0] period4,
    output logic [CNT_W-1:0] period16,
    output logic             lock4,
    output logic             lock16,
    output logic             err
);
    logic err_set4, err_set16;
    logic err_q, err_d;

    div_tick_chan #(.CNT_W(CNT_W), .EXP(EXP_P4), .LOCK_CNT(LOCK_CNT)) u_ch4 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_in  (div4_in),
        .tick    (tick4),
        .period  (period4),
        .lock    (lock4),
        .err_set (err_set4)
    );

    div_tick_chan #(.CNT_W(CNT_W), .EXP(EXP_P16), .LOCK_CNT(LOCK_CNT)) u_ch16 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_in  (div16_in),
        .tick    (tick16),
        .period  (period16),
        .lock    (lock16),
        .err_set (err_set16)
    );

    // A new error in the same cycle as clr_err keeps err set.
    always_comb begin
        err_d = err_q;
        if (err_set4 | err_set16) err_d = 1'b1;
        else if (clr_err)         err_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
endmodule
